load_store_unit: RTL and testbench

- Data-memory access stage between the EX-stage control signals (store size select, load select, ALU address) and the synchronous data/MMIO memory port.
- Converts a single-cycle pipeline memory request into a req/ack transaction with variable wait states. Stalls the pipeline while the transaction is outstanding.
- Generates byte write enables and lane-replicated store data; returns the aligned, sign/zero-extended load value for the writeback mux.
- Detects misaligned accesses and memory timeouts.

---
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory access stage: turns a one-cycle EX memory op into a req/ack transaction.
// Latency: accept N, mem_req from N+1, ld_valid/timeout the cycle after ack or abort.
// Backpressure: stall held from accept through the last BUSY cycle; released in DONE.
module load_store_unit #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_ssel,
   input  logic [2:0]  req_ldsel,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_wbe,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        misalign,
   output logic        timeout
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [29:0]       addr_q, addr_d;
   logic              we_q, we_d;
   logic [2:0]        ldsel_q, ldsel_d;
   logic [1:0]        off_q, off_d;
   logic [3:0]        wbe_q, wbe_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       ld_q, ld_d;
   logic              to_q, to_d;

   logic              req_half, req_word, aligned;
   logic [3:0]        wbe_new;
   logic [31:0]       wdata_new;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [31:0]       ld_ext;

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

   // Decode access size, check alignment and build lane-replicated store data.
   always_comb begin
      req_half  = 1'b0;
      req_word  = 1'b0;
      wbe_new   = 4'b0000;
      wdata_new = req_wdata;
      if (req_we) begin
         case (req_ssel)
            2'd0:    req_half = 1'b0;
            2'd1:    req_half = 1'b1;
            default: req_word = 1'b1;
         endcase
      end else begin
         case (req_ldsel)
            3'd0, 3'd4: req_half = 1'b0;
            3'd1, 3'd5: req_half = 1'b1;
            default:    req_word = 1'b1;
         endcase
      end
      aligned = !((req_half && req_addr[0]) || (req_word && (req_addr[1:0] != 2'b00)));
      if (req_we) begin
         if (req_word) begin
            wbe_new = 4'b1111;
         end else if (req_half) begin
            wbe_new   = 4'b0011 << req_addr[1:0];
            wdata_new = {2{req_wdata[15:0]}};
         end else begin
            wbe_new   = 4'b0001 << req_addr[1:0];
            wdata_new = {4{req_wdata[7:0]}};
         end
      end
   end

   // Extract and extend the load lane selected by the registered byte offset.
   always_comb begin
      rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
      rd_half = mem_rdata[{off_q[1], 4'b0000} +: 16];
      case (ldsel_q)
         3'd0:    ld_ext = {{24{rd_byte[7]}}, rd_byte};
         3'd1:    ld_ext = {{16{rd_half[15]}}, rd_half};
         3'd4:    ld_ext = {24'd0, rd_byte};
         3'd5:    ld_ext = {16'd0, rd_half};
         default: ld_ext = mem_rdata;
      endcase
   end

   // Next-state and control outputs; rst gates the combinational accept path.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      we_d     = we_q;
      ldsel_d  = ldsel_q;
      off_d    = off_q;
      wbe_d    = wbe_q;
      wdata_d  = wdata_q;
      ld_d     = ld_q;
      to_d     = 1'b0;
      stall    = 1'b0;
      mem_req  = 1'b0;
      misalign = 1'b0;
      ld_valid = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && !rst) begin
               if (!aligned) begin
                  misalign = 1'b1;
               end else begin
                  stall   = 1'b1;
                  addr_d  = req_addr[31:2];
                  we_d    = req_we;
                  ldsel_d = req_ldsel;
                  off_d   = req_addr[1:0];
                  wbe_d   = wbe_new;
                  wdata_d = wdata_new;
                  cnt_d   = '0;
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ack) begin
               if (!we_q) ld_d = ld_ext;
               cnt_d   = '0;
               state_d = DONE;
            end else if (cnt_q == LAST_WAIT) begin
               // MAX_WAIT cycles of mem_req without ack: abort.
               if (!we_q) ld_d = 32'd0;
               to_d    = 1'b1;
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            ld_valid = !we_q;
            timeout  = to_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_we    = mem_req & we_q;
   assign mem_addr  = addr_q;
   assign mem_wbe   = wbe_q;
   assign mem_wdata = wdata_q;
   assign ld_data   = ld_q;

   // State and captured request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         ldsel_q <= '0;
         off_q   <= '0;
         wbe_q   <= '0;
         wdata_q <= '0;
         ld_q    <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         ldsel_q <= ldsel_d;
         off_q   <= off_d;
         wbe_q   <= wbe_d;
         wdata_q <= wdata_d;
         ld_q    <= ld_d;
         to_q    <= to_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: load results are queued at issue and matched on ld_valid.
// Latency: each op runs accept, BUSY (wait states + ack), DONE.
// Backpressure: mem_ack is driven directly to model variable wait states.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_ssel;
   logic [2:0]  req_ldsel;
   logic        stall, mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_wbe;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] ld_data;
   logic        ld_valid, misalign, timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int stall_cnt = 0, req_cnt = 0, vld_cnt = 0;
   logic [31:0] sb[$];

   load_store_unit #(.MAX_WAIT(15), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ssel(req_ssel), .req_ldsel(req_ldsel),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wbe(mem_wbe), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .ld_data(ld_data), .ld_valid(ld_valid),
      .misalign(misalign), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Cycle counters and scoreboard pop, sampled away from the active edge.
   always @(negedge clk) begin
      if (stall)   stall_cnt++;
      if (mem_req) req_cnt++;
      if (ld_valid) begin
         vld_cnt++;
         if (sb.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
         else                chk("ld_data", ld_data, sb.pop_front());
      end
   end

   // One aligned transaction; entered and left at posedge+1 in IDLE with req_valid still high.
   task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] ssel, input logic [2:0] ldsel,
                        input logic [31:0] rdata, input int wait_n, input logic [31:0] exp_ld,
                        input logic [3:0] exp_wbe, input logic [31:0] exp_wdata);
      int s0, v0, r0;
      s0 = stall_cnt; v0 = vld_cnt; r0 = req_cnt;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      req_ssel = ssel; req_ldsel = ldsel;
      if (!we) sb.push_back(exp_ld);
      @(negedge clk);
      chk("accept_stall", {31'd0, stall}, 32'd1);
      chk("accept_misalign", {31'd0, misalign}, 32'd0);
      chk("accept_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      for (int i = 0; i <= wait_n; i++) begin
         mem_ack   = (i == wait_n);
         mem_rdata = (i == wait_n) ? rdata : ~rdata;
         @(negedge clk);
         chk("busy_req", {31'd0, mem_req}, 32'd1);
         if (i == 0) begin
            chk("mem_addr", {2'b00, mem_addr}, {2'b00, addr[31:2]});
            chk("mem_wbe", {28'd0, mem_wbe}, {28'd0, exp_wbe});
            chk("mem_we", {31'd0, mem_we}, {31'd0, we});
            if (we) chk("mem_wdata", mem_wdata, exp_wdata);
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      @(negedge clk);
      chk("done_stall", {31'd0, stall}, 32'd0);
      chk("done_req", {31'd0, mem_req}, 32'd0);
      chk("done_vld", {31'd0, ld_valid}, {31'd0, !we});
      chk("done_timeout", {31'd0, timeout}, 32'd0);
      @(posedge clk); #1;
      chk("stall_cycles", stall_cnt - s0, wait_n + 2);
      chk("req_cycles", req_cnt - r0, wait_n + 1);
      chk("vld_cycles", vld_cnt - v0, we ? 32'd0 : 32'd1);
   endtask

   initial begin
      int n, v0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      req_ssel = '0; req_ldsel = '0; mem_ack = 1'b0; mem_rdata = '0;
      #12;
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_req", {31'd0, mem_req}, 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_pulses", {29'd0, ld_valid, misalign, timeout}, 32'd0);
      chk("rst_wbe_addr", {mem_wbe, mem_addr[27:0]}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // LB, two wait states, sign-extended top byte.
      do_op(1'b0, 32'h0000_1003, 32'h0, 2'd0, 3'd0, 32'h80FF_1234, 2, 32'hFFFF_FF80, 4'b0000, 32'h0);
      // SH upper half, immediate ack.
      do_op(1'b1, 32'h0000_2002, 32'hDEAD_BEEF, 2'd1, 3'd0, 32'h0, 0, 32'h0, 4'b1100, 32'hBEEF_BEEF);
      req_valid = 1'b0;

      // Misaligned LW is rejected without a memory request.
      @(posedge clk); #1;
      v0 = req_cnt;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0006; req_ldsel = 3'd2;
      @(negedge clk);
      chk("mis_pulse", {31'd0, misalign}, 32'd1);
      chk("mis_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("mis_clear", {31'd0, misalign}, 32'd0);
      chk("mis_no_req", req_cnt - v0, 32'd0);
      @(posedge clk); #1;

      // Back-to-back chain of aligned ops, each accepted right after the previous DONE.
      do_op(1'b0, 32'h0000_0006, 32'h0, 2'd0, 3'd5, 32'h8001_0000, 1, 32'h0000_8001, 4'b0000, 32'h0);
      do_op(1'b0, 32'h0000_0002, 32'h0, 2'd0, 3'd1, 32'h8001_0000, 0, 32'hFFFF_8001, 4'b0000, 32'h0);
      do_op(1'b1, 32'h0000_0001, 32'h1234_5678, 2'd0, 3'd0, 32'h0, 0, 32'h0, 4'b0010, 32'h7878_7878);
      do_op(1'b0, 32'h0000_0001, 32'h0, 2'd0, 3'd4, 32'h0000_A500, 3, 32'h0000_00A5, 4'b0000, 32'h0);
      do_op(1'b1, 32'h0000_0008, 32'hCAFE_F00D, 2'd3, 3'd0, 32'h0, 0, 32'h0, 4'b1111, 32'hCAFE_F00D);
      do_op(1'b0, 32'h0000_000C, 32'h0, 2'd0, 3'd2, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'b0000, 32'h0);
      req_valid = 1'b0;

      // Timeout: no ack, mem_req must last exactly MAX_WAIT cycles, then ld_data forced to 0.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010; req_ldsel = 3'd2;
      sb.push_back(32'h0);
      v0 = vld_cnt;
      @(negedge clk);
      chk("to_accept", {31'd0, stall}, 32'd1);
      @(posedge clk); #1;
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         if (!mem_req) break;
         n++;
         @(posedge clk); #1;
      end
      chk("to_req_cycles", n, 32'd15);
      chk("to_pulse", {31'd0, timeout}, 32'd1);
      chk("to_vld", {31'd0, ld_valid}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("to_after", {30'd0, timeout, mem_req}, 32'd0);
      chk("to_vld_cycles", vld_cnt - v0, 32'd1);
      @(posedge clk); #1;

      // Reset during BUSY: request drops at once, a late ack is ignored.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0020; req_ldsel = 3'd2;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rb_busy", {31'd0, mem_req}, 32'd1);
      v0 = vld_cnt;
      #2 rst = 1'b1; req_valid = 1'b0;
      #1;
      chk("rb_req_drop", {31'd0, mem_req}, 32'd0);
      chk("rb_stall_drop", {31'd0, stall}, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rb_no_vld", vld_cnt - v0, 32'd0);
      chk("rb_ld_data", ld_data, 32'd0);
      chk("rb_idle", {31'd0, mem_req}, 32'd0);
      chk("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
